// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter: FSM states, read fill byte and
// the opcodes that switch the flash into dual/quad I/O.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStart,
    StWait,
    StHold,
    StGap
  } state_e;

  // Byte shifted out on a read so SDO idles high.
  localparam logic [7:0] READ_FILL = 8'hFF;

  // Opcodes that would make the flash drive its IO pins, including SDI,
  // against the FPGA. They are rejected when written as an opcode.
  localparam int unsigned NUM_FORBIDDEN = 8;
  localparam logic [NUM_FORBIDDEN-1:0][7:0] FORBIDDEN_OPS = {
    8'h3B, 8'h6B, 8'hEB, 8'hBB, 8'h77, 8'h32, 8'h92, 8'h94
  };

endpackage

// File: rtl/spi_opcode_filter.sv
// Combinational check of an outgoing opcode against the forbidden list.
module spi_opcode_filter
  import spi_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic       wr,
  output logic       forbidden
);

  // Reads never put an opcode on the wire, so only writes can be forbidden.
  always_comb begin
    forbidden = 1'b0;
    for (int unsigned i = 0; i < NUM_FORBIDDEN; i++) begin
      if (wr && (opcode == FORBIDDEN_OPS[i])) begin
        forbidden = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of the shared SPI byte engine and flash
// chip-select. Supports locked multi-byte transactions and blocks I/O-mode
// opcodes.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned SS_GAP_CYCLES = 4,
  parameter int unsigned HOLD_TIMEOUT  = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  input  logic [1:0] i_wr,
  input  logic [7:0] i_tx0,
  input  logic [7:0] i_tx1,
  output logic [1:0] o_gnt,
  output logic [1:0] o_done,
  output logic [1:0] o_reject,
  output logic [7:0] o_rx,
  output logic       o_busy,
  output logic       o_eng_start,
  output logic [7:0] o_eng_tx,
  input  logic       i_eng_done,
  input  logic [7:0] i_eng_rx,
  output logic       o_ss_n
);

  localparam logic [7:0]  GAP_LAST  = 8'(SS_GAP_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;        // requester preferred on a tie
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  reject_q, reject_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] idle_q, idle_d;

  logic        sel_wr;
  logic [7:0]  sel_tx;
  logic [7:0]  fill_tx;
  logic [1:0]  owner_mask;
  logic        forbidden;
  logic        active;

  assign sel_wr     = i_wr[owner_q];
  assign sel_tx     = owner_q ? i_tx1 : i_tx0;
  assign fill_tx    = sel_wr ? sel_tx : READ_FILL;
  assign owner_mask = owner_q ? 2'b10 : 2'b01;

  spi_opcode_filter u_filter (
    .opcode    (sel_tx),
    .wr        (sel_wr),
    .forbidden (forbidden)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      done_q   <= 2'b00;
      reject_q <= 2'b00;
      gap_q    <= 8'h00;
      idle_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      gap_q    <= gap_d;
      idle_q   <= idle_d;
    end
  end

  // Next-state logic: arbitration, byte sequencing, hold and gap timing.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    done_d   = 2'b00;
    reject_d = 2'b00;
    gap_d    = gap_q;
    idle_d   = idle_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          owner_d = (i_req == 2'b11) ? rr_q : i_req[1];
          state_d = StSetup;
        end
      end
      StSetup: begin
        tx_d = fill_tx;
        if (forbidden) begin
          done_d   = owner_mask;
          reject_d = owner_mask;
          gap_d    = 8'h00;
          state_d  = StGap;
        end else begin
          state_d = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (i_eng_done) begin
          rx_d    = i_eng_rx;
          done_d  = owner_mask;
          idle_d  = 32'd0;
          gap_d   = 8'h00;
          state_d = i_lock[owner_q] ? StHold : StGap;
        end
      end
      StHold: begin
        idle_d = idle_q + 32'd1;
        // done_q set means this is the o_done cycle: request/lock not yet valid.
        if (!(|done_q) && i_req[owner_q]) begin
          tx_d    = fill_tx;
          idle_d  = 32'd0;
          state_d = StStart;
        end else if (!(|done_q) && !i_lock[owner_q]) begin
          gap_d   = 8'h00;
          state_d = StGap;
        end else if ((HOLD_TIMEOUT != 0) && (idle_q == HOLD_LAST)) begin
          gap_d   = 8'h00;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GAP_LAST) begin
          rr_d    = ~owner_q;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'h01;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; reset forces chip-select high at once.
  always_comb begin
    active      = (state_q == StSetup) || (state_q == StStart) ||
                  (state_q == StWait)  || (state_q == StHold);
    o_gnt       = active ? owner_mask : 2'b00;
    o_ss_n      = ~active;
    o_busy      = (state_q != StIdle);
    o_eng_start = (state_q == StStart);
    o_eng_tx    = tx_q;
    o_done      = done_q;
    o_reject    = reject_q;
    o_rx        = rx_q;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with a simple byte-engine model.
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, lock, wr;
  logic [7:0] tx0, tx1;
  logic [1:0] gnt, done, reject;
  logic [7:0] rx, eng_tx;
  logic       busy, eng_start, ss_n;
  logic       eng_done = 1'b0;
  logic [7:0] eng_rx = 8'h00;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ss_hi = 0;
  int start_cnt = 0;
  int eng_cnt = 0;
  int eng_lat = 16;
  int done_at = -1;
  logic [7:0] eng_rx_val = 8'hEF;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_arbiter #(
    .SS_GAP_CYCLES (4),
    .HOLD_TIMEOUT  (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_lock      (lock),
    .i_wr        (wr),
    .i_tx0       (tx0),
    .i_tx1       (tx1),
    .o_gnt       (gnt),
    .o_done      (done),
    .o_reject    (reject),
    .o_rx        (rx),
    .o_busy      (busy),
    .o_eng_start (eng_start),
    .o_eng_tx    (eng_tx),
    .i_eng_done  (eng_done),
    .i_eng_rx    (eng_rx),
    .o_ss_n      (ss_n)
  );

  // Byte engine model: done pulse eng_lat cycles after a start; ignores DUT reset.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_cnt != 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_rx   = eng_rx_val;
        done_at  = cyc;
      end
    end else if (eng_start) begin
      eng_cnt   = eng_lat;
      start_cnt = start_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (ss_n) ss_hi++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done != 2'b00) return;
    end
  endtask

  task automatic wait_start(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (eng_start) return;
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy) return;
      tick();
    end
  endtask

  initial begin
    int n;
    int s0;
    int t_rst;
    int d_seen;
    rst_n = 1'b0; req = 2'b00; lock = 2'b00; wr = 2'b00; tx0 = 8'h00; tx1 = 8'h00;
    repeat (3) tick();
    chk("rst_ss_n", ss_n, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx", rx, 0);
    chk("rst_done", done, 0);
    chk("rst_start", eng_start, 0);
    rst_n = 1'b1;
    tick();

    // Single unlocked write of 9F from requester 0.
    req = 2'b01; wr = 2'b01; tx0 = 8'h9F; eng_lat = 16; eng_rx_val = 8'hEF;
    tick();
    chk("t1_setup_ss_n", ss_n, 0);
    chk("t1_setup_gnt", gnt, 2'b01);
    chk("t1_setup_start", eng_start, 0);
    tick();
    chk("t1_start", eng_start, 1);
    chk("t1_eng_tx", eng_tx, 8'h9F);
    wait_done(40);
    chk("t1_done", done, 2'b01);
    chk("t1_rx", rx, 8'hEF);
    chk("t1_done_lat", cyc - done_at, 1);
    chk("t1_starts", start_cnt, 1);
    req = 2'b00;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      if (ss_n) n++;
      tick();
    end
    chk("t1_gap_len", n, 4);

    // Round robin on two back-to-back ties.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req = 2'b11; wr = 2'b11; tx0 = 8'h01; tx1 = 8'h05; lock = 2'b00; eng_lat = 4;
    tick();
    chk("t2_gnt_first", gnt, 2'b01);
    wait_done(40);
    chk("t2_done_first", done, 2'b01);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt != 2'b00) break;
    end
    chk("t2_gnt_second", gnt, 2'b10);
    wait_done(40);
    chk("t2_done_second", done, 2'b10);
    req = 2'b00;
    wait_idle(20);
    chk("t2_idle", busy, 0);

    // Requester 1 locked: opcode 03 then three reads, requester 0 waiting.
    req = 2'b10; wr = 2'b10; tx1 = 8'h03; lock = 2'b10; eng_rx_val = 8'hC3;
    tick();
    chk("t3_gnt", gnt, 2'b10);
    ss_hi = 0;
    req = 2'b11; wr = 2'b11; tx0 = 8'h9F;
    wait_done(40);
    chk("t3_op_done", done, 2'b10);
    wr = 2'b01;
    for (int b = 0; b < 3; b++) begin
      eng_rx_val = 8'h10 + 8'(b);
      wait_start(10);
      chk("t3_rd_start", eng_start, 1);
      chk("t3_rd_tx", eng_tx, 8'hFF);
      chk("t3_rd_gnt", gnt, 2'b10);
      wait_done(40);
      chk("t3_rd_done", done, 2'b10);
      chk("t3_rd_rx", rx, 32'h10 + 32'(b));
    end
    chk("t3_ss_held", ss_hi, 0);
    req = 2'b01; lock = 2'b00;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gnt == 2'b01) break;
      if (ss_n) n++;
    end
    chk("t3_gap_before_r0", n, 5);
    chk("t3_gnt_r0", gnt, 2'b01);
    wait_done(40);
    chk("t3_r0_done", done, 2'b01);
    req = 2'b00;
    wait_idle(20);

    // Forbidden write opcode EB: rejected without touching the engine.
    s0 = start_cnt;
    req = 2'b01; wr = 2'b01; tx0 = 8'hEB;
    wait_done(40);
    chk("t4_done", done, 2'b01);
    chk("t4_reject", reject, 2'b01);
    chk("t4_ss_n", ss_n, 1);
    chk("t4_no_start", start_cnt, s0);
    req = 2'b00;
    wait_idle(20);
    // Same value as a read is allowed and shifts FF.
    req = 2'b01; wr = 2'b00; tx0 = 8'h3B; eng_rx_val = 8'h5A;
    wait_start(10);
    chk("t4_read_tx", eng_tx, 8'hFF);
    wait_done(40);
    chk("t4_read_done", done, 2'b01);
    chk("t4_read_noreject", reject, 2'b00);
    req = 2'b00;
    wait_idle(20);
    // Last list entry from requester 1.
    req = 2'b10; wr = 2'b10; tx1 = 8'h92;
    wait_done(40);
    chk("t4_r1_reject", reject, 2'b10);
    req = 2'b00;
    wait_idle(20);

    // Locked owner goes idle: forced release after HOLD_TIMEOUT cycles.
    req = 2'b01; wr = 2'b01; tx0 = 8'h06; lock = 2'b01;
    wait_done(40);
    chk("t5_done", done, 2'b01);
    req = 2'b00;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ss_n) break;
      n++;
    end
    chk("t5_hold_cycles", n, 7);
    chk("t5_released", ss_n, 1);
    lock = 2'b00;
    wait_idle(20);

    // Reset while waiting on the engine.
    req = 2'b01; wr = 2'b01; tx0 = 8'h9F; eng_lat = 16;
    wait_start(10);
    tick(); tick();
    chk("t6_in_wait", busy, 1);
    rst_n = 1'b0;
    t_rst = cyc;
    #1;
    chk("t6_rst_ss_n", ss_n, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_gnt", gnt, 0);
    req = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    d_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done != 2'b00) d_seen++;
    end
    chk("t6_late_eng_done", 32'(done_at > t_rst), 1);
    chk("t6_no_done", d_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI byte engine (SCK/SDO/SDI shifter) and flash chip-select between two requesters: requester 0 is the CPU I/O-port path and requester 1 is the flash-read/boot sequencer.
- Sequences chip-select, byte starts and completion handshakes, and holds the bus for a locked multi-byte transaction.
- Blocks forbidden dual/quad-I/O opcodes so the flash IC never drives SPI_SDI against the FPGA.
- Exports a busy flag for CPU wait-state generation.

Parameters:
- SS_GAP_CYCLES, 4, minimum i_clk cycles o_ss_n stays high between transactions (range 1..255).
- HOLD_TIMEOUT, 1024, i_clk cycles a locked owner may idle in HOLD before forced release (0 = never).

Ports:
- i_clk  in  1  FPGA clock, 100 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  2  per-requester byte request; level, one bit per requester.
- i_lock  in  2  keep chip-select asserted after the current byte.
- i_wr  in  2  1 = write i_txN; 0 = read (shift out 8'hFF).
- i_tx0  in  8  requester 0 transmit byte.
- i_tx1  in  8  requester 1 transmit byte.
- o_gnt  out  2  one-hot current owner; 0 when idle or in gap.
- o_done  out  2  one-cycle pulse to the owner: byte finished or rejected.
- o_reject  out  2  one-cycle pulse, coincident with o_done: forbidden opcode.
- o_rx  out  8  received byte; valid in the o_done cycle, held until the next o_done.
- o_busy  out  1  high whenever state != IDLE.
- o_eng_start  out  1  one-cycle pulse to the byte engine.
- o_eng_tx  out  8  byte for the engine; stable from the start pulse until i_eng_done.
- i_eng_done  in  1  engine completion pulse.
- i_eng_rx  in  8  engine received byte; valid with i_eng_done.
- o_ss_n  out  1  flash chip-select, active low.

Behaviour:
- Reset (asynchronous): state IDLE, o_ss_n = 1, o_gnt = 0, o_done = 0, o_reject = 0, o_eng_start = 0, o_busy = 0, o_rx = 8'h00, RR pointer = requester 0, counters cleared.
- Reset mid-transfer: o_ss_n rises immediately. The engine's in-flight i_eng_done is ignored after reset.
- State IDLE: if any i_req is set, grant by round-robin. The requester not served last wins a tie; after reset, requester 0 wins. Next state SETUP.
- State SETUP (1 cycle):
  - o_gnt = owner and o_ss_n = 0.
  - Capture tx = i_wr ? i_txN : 8'hFF.
  - First byte of the transaction is an opcode; run the filter on it.
  - Forbidden when i_wr = 1 and byte is in {3B, 6B, EB, BB, 77, 32, 92, 94}.
  - Forbidden: pulse o_done and o_reject, do not start the engine, go to GAP.
  - Otherwise go to START.
- State START (1 cycle): o_eng_start = 1, then WAIT.
- State WAIT:
  - Hold o_eng_tx until i_eng_done.
  - On i_eng_done: o_rx <= i_eng_rx, and o_done pulses the following cycle.
  - i_lock[owner], sampled in the i_eng_done cycle, selects HOLD (1) or GAP (0).
  - Dropping i_req during WAIT does not abort; done still pulses.
- State HOLD:
  - o_ss_n stays 0 and o_gnt stays owner.
  - i_req[owner] is ignored in the o_done cycle. From the next cycle, i_req[owner] = 1 captures a new tx and goes directly to START, with no filter (not an opcode).
  - i_lock[owner] = 0 with no req: go to GAP.
  - The idle counter reaches HOLD_TIMEOUT: go to GAP.
  - The other requester is never granted while in HOLD.
- State GAP:
  - o_ss_n = 1 and o_gnt = 0 for SS_GAP_CYCLES cycles.
  - Update the RR pointer to the other requester, then go to IDLE.
- i_eng_done outside WAIT: ignored.
- Arbitration happens only in IDLE; requests arriving during GAP wait.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding (IDLE, SETUP, START, WAIT, HOLD, GAP);
  - the forbidden-opcode list as constants;
  - the READ_FILL = 8'hFF constant.
- One natural sub-module: spi_opcode_filter, a combinational byte plus write flag to forbidden flag, reusable by the status-register path.
- The byte engine stays a separate instance.

Test Plan:
- Reset, then i_req = 2'b01, i_wr0 = 1, i_tx0 = 8'h9F, lock = 0; engine returns i_eng_rx = 8'hEF after 16 cycles:
  - o_ss_n falls in the SETUP cycle;
  - o_eng_start pulses once with o_eng_tx = 9F;
  - o_done = 01 and o_rx = EF one cycle after i_eng_done;
  - o_ss_n high for exactly 4 cycles before IDLE.
- Simultaneous i_req = 2'b11 twice in succession: first grant goes to 01, second grant to 10; o_gnt never shows both bits.
- Requester 1, lock = 1: opcode 8'h03 then three read bytes:
  - o_ss_n stays 0 across all four bytes;
  - read bytes show o_eng_tx = FF;
  - a concurrent i_req[0] is not granted until after GAP.
- Requester 0 write of opcode 8'hEB:
  - no o_eng_start;
  - o_done[0] and o_reject[0] pulse together;
  - o_ss_n returns to 1.
- Lock held, owner idle: with HOLD_TIMEOUT = 8, o_ss_n rises 8 cycles after o_done.
- Reset asserted in WAIT:
  - o_ss_n = 1 and o_busy = 0 asynchronously;
  - a late i_eng_done produces no o_done.
